// File: rtl/reg_arb_pkg.sv
// Shared types, constants and the round-robin pick rule for reg_access_arbiter.
package reg_arb_pkg;

  // Widest configuration supported by the shared pick function and error word.
  localparam int MAX_HOSTS  = 8;
  localparam int MAX_PTR_W  = 3;
  localparam int MAX_DATA_W = 64;

  // Timeout counter width; TIMEOUT is limited to 1..255.
  localparam int CNT_W = 8;

  // Read data returned on a timeout abort; sliced down to DATA_W by the user.
  localparam logic [MAX_DATA_W-1:0] RDATA_ERR = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  // First requesting index at or after ptr, wrapping modulo n.
  // Returns ptr unchanged when nothing is requesting; callers qualify with |req.
  function automatic logic [MAX_PTR_W-1:0] rr_pick(input logic [MAX_HOSTS-1:0] req,
                                                   input logic [MAX_PTR_W-1:0] ptr,
                                                   input int                   n);
    logic                 found;
    logic [MAX_PTR_W-1:0] idx;
    found   = 1'b0;
    rr_pick = ptr;
    for (int k = 0; k < MAX_HOSTS; k++) begin
      idx = MAX_PTR_W'((int'(ptr) + k) % n);
      if (k < n && !found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/reg_access_arbiter_rr_grant.sv
// Combinational round-robin picker: chooses the next host to serve from the
// request vector, starting the search at the rotating pointer.
module rr_grant
  import reg_arb_pkg::*;
#(
  parameter int N_HOSTS = 4,
  parameter int PTR_W   = $clog2(N_HOSTS)
) (
  input  logic [N_HOSTS-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               grant_valid
);

  logic [MAX_HOSTS-1:0] req_ext;
  logic [MAX_PTR_W-1:0] ptr_ext;
  logic [MAX_PTR_W-1:0] pick;

  assign req_ext = MAX_HOSTS'(req);
  assign ptr_ext = MAX_PTR_W'(ptr);

  // Pure function of the current requests and pointer; no storage here.
  always_comb begin
    pick = rr_pick(req_ext, ptr_ext, N_HOSTS);
  end

  assign grant_idx   = PTR_W'(pick);
  assign grant_valid = |req;

endmodule

// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter sharing one device-side register port among N_HOSTS
// requesters. Serialises transactions, returns read data and aborts a device
// access that does not acknowledge within TIMEOUT busy cycles.
module reg_access_arbiter
  import reg_arb_pkg::*;
#(
  parameter int N_HOSTS = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_HOSTS-1:0]        host_req,
  input  logic [N_HOSTS-1:0]        host_we,
  input  logic [N_HOSTS*ADDR_W-1:0] host_addr,
  input  logic [N_HOSTS*DATA_W-1:0] host_wdata,
  output logic [N_HOSTS-1:0]        host_ack,
  output logic                      host_err,
  output logic [DATA_W-1:0]         host_rdata,
  output logic                      dev_req,
  output logic                      dev_we,
  output logic [ADDR_W-1:0]         dev_addr,
  output logic [DATA_W-1:0]         dev_wdata,
  input  logic                      dev_ack,
  input  logic [DATA_W-1:0]         dev_rdata
);

  localparam int                PTR_W     = $clog2(N_HOSTS);
  localparam logic [PTR_W-1:0]  LAST_HOST = PTR_W'(N_HOSTS - 1);
  // Counter value in the last allowed busy cycle; an ack seen here still wins.
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] ERR_WORD  = DATA_W'(RDATA_ERR);

  arb_state_e       state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] grant;
  logic [CNT_W-1:0] cnt;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_valid;

  rr_grant #(
    .N_HOSTS (N_HOSTS),
    .PTR_W   (PTR_W)
  ) u_rr_grant (
    .req         (host_req),
    .ptr         (rr_ptr),
    .grant_idx   (pick_idx),
    .grant_valid (pick_valid)
  );

  // Arbitration FSM with every host- and device-side output registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant      <= '0;
      cnt        <= '0;
      dev_req    <= 1'b0;
      dev_we     <= 1'b0;
      dev_addr   <= '0;
      dev_wdata  <= '0;
      host_ack   <= '0;
      host_err   <= 1'b0;
      host_rdata <= '0;
    end else begin
      // NOTE: non-blocking assignments here, so the default clear of host_ack
      // below and the later set of one bit resolve to "last write wins" at the
      // edge without any ordering hazard against other clocked blocks.
      host_ack <= '0;
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            grant     <= pick_idx;
            dev_req   <= 1'b1;
            dev_we    <= host_we[pick_idx];
            dev_addr  <= host_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
            dev_wdata <= host_wdata[int'(pick_idx)*DATA_W +: DATA_W];
            cnt       <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (dev_ack) begin
            host_rdata      <= dev_we ? '0 : dev_rdata;
            host_err        <= 1'b0;
            dev_req         <= 1'b0;
            host_ack[grant] <= 1'b1;
            state           <= DONE;
          end else if (cnt == CNT_LAST) begin
            host_rdata      <= ERR_WORD;
            host_err        <= 1'b1;
            dev_req         <= 1'b0;
            host_ack[grant] <= 1'b1;
            state           <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          rr_ptr <= (grant == LAST_HOST) ? '0 : grant + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Self-checking bench for reg_access_arbiter: directed scenarios followed by a
// randomized phase, checked against a rotating-priority model and a device
// register array kept in the bench.
module tb_reg_access_arbiter;

  localparam int N      = 4;
  localparam int AW     = 8;
  localparam int DW     = 16;
  localparam int TO     = 15;
  localparam int NO_ACK = 1000;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    host_req;
  logic [N-1:0]    host_we;
  logic [N*AW-1:0] host_addr;
  logic [N*DW-1:0] host_wdata;
  logic [N-1:0]    host_ack;
  logic            host_err;
  logic [DW-1:0]   host_rdata;
  logic            dev_req;
  logic            dev_we;
  logic [AW-1:0]   dev_addr;
  logic [DW-1:0]   dev_wdata;
  logic            dev_ack;
  logic [DW-1:0]   dev_rdata;

  int            n_vec  = 0;
  int            n_miss = 0;
  int            ptr_m  = 0;      // next host to be favoured, per the fairness rule
  logic [DW-1:0] mem [256];       // device register file contents

  always #5 clk = ~clk;

  reg_access_arbiter #(
    .N_HOSTS (N),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_err   (host_err),
    .host_rdata (host_rdata),
    .dev_req    (dev_req),
    .dev_we     (dev_we),
    .dev_addr   (dev_addr),
    .dev_wdata  (dev_wdata),
    .dev_ack    (dev_ack),
    .dev_rdata  (dev_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_host(input int h, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    host_req[h]             = 1'b1;
    host_we[h]              = we;
    host_addr[h*AW +: AW]   = a;
    host_wdata[h*DW +: DW]  = wd;
  endtask

  // Expected winner: first requester scanning upward from ptr_m, wrapping.
  function automatic int model_pick(input logic [N-1:0] req);
    for (int k = 0; k < N; k++)
      if (req[(ptr_m + k) % N]) return (ptr_m + k) % N;
    return -1;
  endfunction

  // Runs one transaction from IDLE (requests already applied). The device
  // acknowledges in busy cycle number `delay` (0 = first); delays of TO or
  // more never get acknowledged before the abort.
  task automatic serve(input int delay, input bit drop_early);
    int            g, lat, busy, exp_busy;
    logic          w, exp_err;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, exp_rd;
    g = model_pick(host_req);
    if (g < 0) begin
      check("serve_has_request", 32'd0, 32'd1);
      return;
    end
    w  = host_we[g];
    a  = host_addr[g*AW +: AW];
    wd = host_wdata[g*DW +: DW];
    lat = 0;
    while (dev_req !== 1'b1 && lat < 8) begin
      tick();
      lat++;
    end
    check("grant_latency", lat, 1);
    if (dev_req !== 1'b1) return;
    check("dev_we", {31'd0, dev_we}, {31'd0, w});
    check("dev_addr", {24'd0, dev_addr}, {24'd0, a});
    check("dev_wdata", {16'd0, dev_wdata}, {16'd0, wd});
    if (drop_early) host_req[g] = 1'b0;
    exp_err  = (delay >= TO);
    exp_busy = exp_err ? TO : delay + 1;
    exp_rd   = exp_err ? '1 : (w ? '0 : mem[a]);
    busy = 1;
    forever begin
      if (busy - 1 == delay) begin
        dev_ack   = 1'b1;
        dev_rdata = w ? DW'($urandom) : mem[a];
      end
      tick();
      dev_ack   = 1'b0;
      dev_rdata = DW'($urandom);
      if (dev_req !== 1'b1 || busy > TO + 4) break;
      check("no_early_ack", {28'd0, host_ack}, 32'd0);
      busy++;
    end
    check("busy_cycles", busy, exp_busy);
    check("host_ack", {28'd0, host_ack}, 32'd1 << g);
    check("host_err", {31'd0, host_err}, {31'd0, exp_err});
    check("host_rdata", {16'd0, host_rdata}, {16'd0, exp_rd});
    if (!exp_err && w) mem[a] = wd;
    ptr_m       = (g + 1) % N;
    host_req[g] = 1'b0;
    tick();
    check("ack_one_cycle", {28'd0, host_ack}, 32'd0);
    check("dev_req_low", {31'd0, dev_req}, 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    host_req   = '0;
    host_we    = '0;
    host_addr  = '0;
    host_wdata = '0;
    dev_ack    = 1'b0;
    dev_rdata  = '0;
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset values
    check("rst_dev_req", {31'd0, dev_req}, 32'd0);
    check("rst_dev_addr", {24'd0, dev_addr}, 32'd0);
    check("rst_dev_wdata", {16'd0, dev_wdata}, 32'd0);
    check("rst_dev_we", {31'd0, dev_we}, 32'd0);
    check("rst_host_ack", {28'd0, host_ack}, 32'd0);
    check("rst_host_err", {31'd0, host_err}, 32'd0);
    check("rst_host_rdata", {16'd0, host_rdata}, 32'd0);

    // All four hosts at once, twice: order 0,1,2,3 each round
    for (int round = 0; round < 2; round++) begin
      for (int h = 0; h < N; h++) set_host(h, 1'b0, AW'(8'h20 + h), DW'(h));
      for (int h = 0; h < N; h++) begin
        check("rr_order", model_pick(host_req), h);
        serve(h % 2, 1'b0);
      end
    end

    // Single write from host 2, device acks after 2 cycles
    set_host(2, 1'b1, 8'h10, 16'hCDEF);
    serve(2, 1'b0);

    // Single read from host 0 of a known value
    mem[8'h04] = 16'h00AC;
    set_host(0, 1'b0, 8'h04, 16'h0000);
    serve(0, 1'b0);
    check("read_00AC", {16'd0, host_rdata}, 32'h0000_00AC);

    // Device never acks, then an ack on the exact timeout cycle
    set_host(1, 1'b0, 8'h33, 16'h0000);
    serve(NO_ACK, 1'b0);
    mem[8'h34] = 16'h5A5A;
    set_host(3, 1'b0, 8'h34, 16'h0000);
    serve(TO - 1, 1'b0);
    check("late_ack_rdata", {16'd0, host_rdata}, 32'h0000_5A5A);

    // Stray device ack while idle is ignored
    dev_ack = 1'b1;
    tick();
    dev_ack = 1'b0;
    tick();
    check("stray_ack_host_ack", {28'd0, host_ack}, 32'd0);
    check("stray_ack_dev_req", {31'd0, dev_req}, 32'd0);

    // Requester drops its request right after the grant; completion still pulses
    set_host(1, 1'b1, 8'h05, 16'h1234);
    serve(1, 1'b1);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      int sel, d;
      for (int h = 0; h < N; h++)
        if (!host_req[h] && $urandom_range(0, 1) == 1)
          set_host(h, 1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom));
      if (host_req == '0) set_host(it % N, 1'b0, AW'(it % 16), '0);
      sel = $urandom_range(0, 9);
      d = (sel < 7) ? sel % 4 : (sel == 7) ? TO - 1 : (sel == 8) ? TO : NO_ACK;
      serve(d, $urandom_range(0, 3) == 0);
    end
    host_req = '0;
    tick();
    tick();

    // Reset in the middle of a transaction
    set_host(1, 1'b0, 8'h01, '0);
    serve(0, 1'b0);
    set_host(2, 1'b1, 8'h02, 16'hBEEF);
    tick();
    check("pre_rst_dev_req", {31'd0, dev_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_dev_req", {31'd0, dev_req}, 32'd0);
    host_req = '0;
    ptr_m    = 0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_ack_after_rst", {28'd0, host_ack}, 32'd0);
    end
    set_host(0, 1'b0, 8'h40, '0);
    set_host(3, 1'b0, 8'h43, '0);
    serve(0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
